// File: rtl/ifetch_unit.sv
// Instruction-fetch stage for the multi-cycle-memory MIPS core: owns the PC,
// runs a req/ack read to instruction memory, holds the fetched word and forms the next PC at commit.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] RA,
  input  logic        ex_done,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] retired,
  output logic        fetch_err
);

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] retired_q;
  logic        err_q;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] npc;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (NPCOp)
      NPC_PLUS4:  npc = pc_plus4;
      NPC_BRANCH: npc = pc_plus4 + br_off;
      NPC_JUMP:   npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      NPC_JR:     npc = RA;
      default:    npc = pc_plus4;
    endcase
  end

  // The request is a pure function of state, so no input can reach im_req/im_addr combinationally.
  assign im_req      = (state_q == S_FETCH);
  assign im_addr     = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign PC_plus4    = pc_plus4;
  assign retired     = retired_q;
  assign fetch_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RESET;
      instr_q   <= 32'd0;
      valid_q   <= 1'b0;
      retired_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (im_ack) begin
            instr_q <= im_rdata;
            valid_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ex_done) begin
            valid_q <= 1'b0;
            // A misaligned target stops the core; the PC keeps the faulting instruction's address.
            if (npc[1:0] == 2'b00) begin
              pc_q      <= npc;
              retired_q <= retired_q + 32'd1;
              state_q   <= S_FETCH;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_HALT;
            end
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: two instances (reset PC 0 and 0xFFFF_FFFC) share stimulus;
// a per-instance fetch/commit model is compared on every falling edge.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  NPCOp;
  logic [31:0] RA;
  logic        ex_done;
  logic        im_ack;
  logic [31:0] im_rdata;

  logic        d_req   [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_instr [2];
  logic        d_valid [2];
  logic [31:0] d_pc    [2];
  logic [31:0] d_pc4   [2];
  logic [31:0] d_ret   [2];
  logic        d_err   [2];

  int n_cmp = 0;
  int n_bad = 0;

  ifetch_unit #(.PC_RESET(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .NPCOp(NPCOp), .RA(RA), .ex_done(ex_done),
    .im_req(d_req[0]), .im_addr(d_addr[0]), .im_ack(im_ack), .im_rdata(im_rdata),
    .instr(d_instr[0]), .instr_valid(d_valid[0]), .PC(d_pc[0]), .PC_plus4(d_pc4[0]),
    .retired(d_ret[0]), .fetch_err(d_err[0])
  );

  ifetch_unit #(.PC_RESET(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst), .NPCOp(NPCOp), .RA(RA), .ex_done(ex_done),
    .im_req(d_req[1]), .im_addr(d_addr[1]), .im_ack(im_ack), .im_rdata(im_rdata),
    .instr(d_instr[1]), .instr_valid(d_valid[1]), .PC(d_pc[1]), .PC_plus4(d_pc4[1]),
    .retired(d_ret[1]), .fetch_err(d_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: m_run = first fetch has been requested, m_valid = holding an instruction to execute.
  logic [31:0] m_pc    [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_ret   [2];
  logic        m_valid [2];
  logic        m_run   [2];
  logic        m_halt  [2];
  logic        m_err   [2];
  logic        m_init = 1'b0;

  function automatic logic [31:0] rst_pc(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                          input logic [1:0] op, input logic [31:0] ra);
    int off;
    off = $signed(w[15:0]);
    case (op)
      2'd0:    return pc + 32'd4;
      2'd1:    return pc + 32'd4 + off * 4;
      2'd2:    return ((pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      default: return ra;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) m_init <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pc[i] <= rst_pc(i); m_instr[i] <= 32'd0; m_ret[i] <= 32'd0;
        m_valid[i] <= 1'b0; m_run[i] <= 1'b0; m_halt[i] <= 1'b0; m_err[i] <= 1'b0;
      end else if (m_halt[i]) begin
        m_halt[i] <= 1'b1;
      end else if (!m_run[i]) begin
        m_run[i] <= 1'b1;
      end else if (!m_valid[i]) begin
        if (im_ack) begin
          m_instr[i] <= im_rdata;
          m_valid[i] <= 1'b1;
        end
      end else if (ex_done) begin
        m_valid[i] <= 1'b0;
        if (next_pc(m_pc[i], m_instr[i], NPCOp, RA) % 4 == 0) begin
          m_pc[i]  <= next_pc(m_pc[i], m_instr[i], NPCOp, RA);
          m_ret[i] <= m_ret[i] + 32'd1;
        end else begin
          m_err[i]  <= 1'b1;
          m_halt[i] <= 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d @%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        cmp("im_req", i, 32'(d_req[i]), 32'(m_run[i] && !m_valid[i] && !m_halt[i]));
        cmp("im_addr", i, d_addr[i], m_pc[i]);
        cmp("instr", i, d_instr[i], m_instr[i]);
        cmp("instr_valid", i, 32'(d_valid[i]), 32'(m_valid[i]));
        cmp("PC", i, d_pc[i], m_pc[i]);
        cmp("PC_plus4", i, d_pc4[i], m_pc[i] + 32'd4);
        cmp("retired", i, d_ret[i], m_ret[i]);
        cmp("fetch_err", i, 32'(d_err[i]), 32'(m_err[i]));
      end
    end
  end

  // Precondition: DUT waiting in fetch. Zero-wait ack, then commit in the first execute cycle.
  task automatic run(input logic [31:0] w, input logic [1:0] op, input logic [31:0] ra);
    im_ack = 1'b1; im_rdata = w;
    @(negedge clk);
    im_ack = 1'b0; ex_done = 1'b1; NPCOp = op; RA = ra;
    @(negedge clk);
    ex_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; NPCOp = 2'd0; RA = 32'd0; ex_done = 1'b0; im_ack = 1'b0; im_rdata = 32'd0;
    @(negedge clk);
    cmp("rst_pc", 0, d_pc[0], 32'h0);
    cmp("rst_pc", 1, d_pc[1], 32'hFFFF_FFFC);
    cmp("rst_instr", 0, d_instr[0], 32'h0);
    cmp("rst_req", 0, 32'(d_req[0]), 32'h0);
    cmp("rst_retired", 0, d_ret[0], 32'h0);
    cmp("rst_err", 0, 32'(d_err[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0; im_ack = 1'b1; im_rdata = 32'h2008_0005;
    @(negedge clk);
    cmp("first_req", 0, 32'(d_req[0]), 32'h1);
    cmp("first_addr", 0, d_addr[0], 32'h0);
    @(negedge clk);
    cmp("zw_instr", 0, d_instr[0], 32'h2008_0005);
    cmp("zw_valid", 0, 32'(d_valid[0]), 32'h1);
    cmp("zw_req_off", 0, 32'(d_req[0]), 32'h0);
    ex_done = 1'b1; NPCOp = 2'd0;
    @(negedge clk);
    ex_done = 1'b0; im_ack = 1'b0;
    cmp("plus4_pc", 0, d_pc[0], 32'h4);
    cmp("plus4_ret", 0, d_ret[0], 32'h1);
    cmp("wrap_pc", 1, d_pc[1], 32'h0);

    // Three wait states with a spurious ex_done while waiting.
    for (int k = 0; k < 4; k++) begin
      cmp("ws_req", 0, 32'(d_req[0]), 32'h1);
      cmp("ws_addr", 0, d_addr[0], 32'h4);
      ex_done = (k == 1);
      im_ack = (k == 3);
      im_rdata = 32'h0;
      @(negedge clk);
    end
    im_ack = 1'b0;
    cmp("ws_pc", 0, d_pc[0], 32'h4);
    cmp("ws_ret", 0, d_ret[0], 32'h1);
    cmp("ws_valid", 0, 32'(d_valid[0]), 32'h1);
    ex_done = 1'b1; NPCOp = 2'd3; RA = 32'h10;
    @(negedge clk);
    ex_done = 1'b0;

    run(32'h1109_FFFE, 2'd1, 32'h0);
    cmp("beq_taken", 0, d_pc[0], 32'h0C);
    run(32'h0, 2'd3, 32'h10);
    run(32'h1109_FFFE, 2'd0, 32'h0);
    cmp("beq_not_taken", 0, d_pc[0], 32'h14);
    run(32'h0, 2'd3, 32'h0040_0000);
    run(32'h0800_0040, 2'd2, 32'h0);
    cmp("jump", 0, d_pc[0], 32'h100);

    im_ack = 1'b1; im_rdata = 32'h0;
    @(negedge clk);
    cmp("link_pc4", 0, d_pc4[0], 32'h104);
    ex_done = 1'b1; NPCOp = 2'd3; RA = 32'h3000; im_ack = 1'b0;
    @(negedge clk);
    ex_done = 1'b0;
    cmp("jr", 0, d_pc[0], 32'h3000);
    run(32'h0, 2'd3, 32'hAFFF_FFF0);
    run(32'h0800_0040, 2'd2, 32'h0);
    cmp("jump_hi", 0, d_pc[0], 32'hA000_0100);
    cmp("ret_count", 0, d_ret[0], 32'd10);

    // Misaligned JR target halts the fetch stage until reset.
    im_ack = 1'b1; im_rdata = 32'h0;
    @(negedge clk);
    ex_done = 1'b1; NPCOp = 2'd3; RA = 32'h0000_1002;
    @(negedge clk);
    ex_done = 1'b0;
    cmp("mis_err", 0, 32'(d_err[0]), 32'h1);
    cmp("mis_valid", 0, 32'(d_valid[0]), 32'h0);
    cmp("mis_ret", 0, d_ret[0], 32'd10);
    for (int k = 0; k < 10; k++) begin
      cmp("halt_req", 0, 32'(d_req[0]), 32'h0);
      cmp("halt_pc", 0, d_pc[0], 32'hA000_0100);
      ex_done = k[0];
      @(negedge clk);
    end
    rst = 1'b1; ex_done = 1'b0; im_ack = 1'b0;
    @(negedge clk);
    cmp("clr_err", 0, 32'(d_err[0]), 32'h0);
    cmp("clr_pc", 0, d_pc[0], 32'h0);
    rst = 1'b0;
    @(negedge clk);
    cmp("refetch_req", 0, 32'(d_req[0]), 32'h1);
    cmp("refetch_addr", 0, d_addr[0], 32'h0);

    // Reset lands on a cycle with a pending request and a concurrent ack.
    rst = 1'b1; im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    cmp("mid_instr", 0, d_instr[0], 32'h0);
    cmp("mid_valid", 0, 32'(d_valid[0]), 32'h0);
    cmp("mid_pc", 1, d_pc[1], 32'hFFFF_FFFC);
    rst = 1'b0; im_ack = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch stage for the multi-cycle-memory variant of the single-cycle MIPS core. It owns the PC register and drives a req/ack handshake to instruction memory. It holds the fetched word stable in an instruction register, from which the controller takes Op = instr[31:26] and Funct = instr[5:0]. At each commit it consumes the controller's NPCOp encoding to form the next PC (PLUS4/BRANCH/JUMP/JR).

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset (must be word aligned)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous active-high reset
NPCOp  in  2  next-PC select from controller: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR (jr/jalr)
RA  in  32  rs register value, JR target
ex_done  in  1  single-cycle pulse: current instruction finished executing, commit now
im_req  out  1  instruction-memory read request
im_addr  out  32  byte address of request (= PC)
im_ack  in  1  memory response valid; im_rdata valid same cycle
im_rdata  in  32  fetched instruction word
instr  out  32  held instruction register
instr_valid  out  1  instr holds the instruction at PC and may be executed
PC  out  32  current PC
PC_plus4  out  32  PC + 4 (jal/jalr link value)
retired  out  32  count of committed instructions
fetch_err  out  1  sticky misaligned-target error

Behaviour:
- Reset (rst high at a rising edge) forces: state IDLE, PC=PC_RESET, instr=0, instr_valid=0, retired=0, fetch_err=0; im_req=0. Reset overrides every other event, including an in-flight fetch; an im_ack arriving in a reset cycle is discarded.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: im_req=0. On the next edge, move unconditionally to FETCH (first request appears one cycle after reset deasserts).
- FETCH:
  - im_req=1 (combinational from state) and im_addr=PC, both held stable until im_ack.
  - On im_ack: instr<=im_rdata, instr_valid<=1, state->EXEC. A zero-wait ack (same cycle as first im_req) is legal.
  - ex_done in FETCH is ignored.
- EXEC:
  - im_req=0; instr and PC held stable.
  - On ex_done, evaluate NPC from NPCOp and RA sampled that cycle.
  - If NPC[1:0]==00: PC<=NPC, instr_valid<=0, retired<=retired+1, state->FETCH.
  - Otherwise: fetch_err<=1, instr_valid<=0, PC unchanged, retired unchanged, state->HALT.
  - im_ack in EXEC is ignored.
- HALT: im_req=0, all registers hold; exit only via rst.
- NPC arithmetic (all mod 2^32, wrap silently):
  - PLUS4: PC+4.
  - BRANCH: PC+4 + (sign_extend(instr[15:0])<<2).
  - JUMP: {PC_plus4[31:28], instr[25:0], 2'b00}.
  - JR: RA.
- PC_plus4 = PC+4 combinational; 0xFFFF_FFFC wraps to 0x0000_0000.
- retired wraps 0xFFFF_FFFF -> 0.
- Latency: instruction available (instr_valid=1) one edge after im_ack. Minimum instruction period is 2 cycles (zero-wait ack, ex_done in the first EXEC cycle).
- No combinational path from ex_done/NPCOp/RA to im_req/im_addr; from im_ack, instr_valid changes only at the clock edge.

Test Plan:
- Reset then zero-wait memory: rst 2 cycles, im_ack tied high with im_rdata=0x20080005 -> im_req=1, im_addr=0x0 in the cycle after rst falls; instr=0x20080005 and instr_valid=1 next edge; ex_done with NPCOp=00 -> PC=0x4, retired=1.
- Wait states: ack delayed 3 cycles -> im_req held 1 and im_addr held 0x4 for 4 cycles; a spurious ex_done during wait leaves PC=0x4 and retired unchanged.
- Branch backward: PC=0x10, instr=0x1109FFFE (beq, imm=-2), ex_done with NPCOp=01 -> PC=0x0C. Same instr with NPCOp=00 (not taken) -> PC=0x14.
- Jump/JR: PC=0x0040_0000, instr=0x08000040, NPCOp=10 -> PC=0x0000_0100. Then NPCOp=11 with RA=0x0000_3000 -> PC=0x3000, PC_plus4 was 0x0000_0104 during EXEC.
- Misaligned JR: NPCOp=11, RA=0x0000_1002, ex_done -> fetch_err=1, state HALT, im_req stays 0 for 10 cycles, PC unchanged; rst clears fetch_err and refetches from PC_RESET.
- Wrap and reset mid-fetch: PC_RESET=0xFFFF_FFFC, commit PLUS4 -> PC=0x0; assert rst while im_req=1 with a concurrent im_ack -> instr stays 0, instr_valid=0, PC=PC_RESET.
